// File: rtl/logo_v_animator.sv
// Pipelined "V" logo painter that bounces its own horizontal offset once per frame.
// Optional blinking of the logo is enabled with `define LOGO_V_BLINK_EN.
module logo_v_animator #(
    parameter int X0           = 500,
    parameter int Y0           = 560,
    parameter int STROKE_W     = 5,
    parameter int STROKE_H     = 20,
    parameter int GAP          = 40,
    parameter int DELT_MAX     = 100,
    parameter int STEP         = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic        hit,
    output logic        hit_valid,
    output logic [10:0] delt
);

    if (DELT_MAX <= 0 || DELT_MAX >= 1024) begin : g_bad_delt_max
        $error("DELT_MAX out of range");
    end
    if (STEP < 1 || STEP > DELT_MAX) begin : g_bad_step
        $error("STEP out of range");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be positive");
    end

    localparam logic signed [12:0] X0_S  = 13'(X0);
    localparam logic signed [12:0] Y0_S  = 13'(Y0);
    localparam logic signed [12:0] GAP_S = 13'(GAP);
    localparam logic signed [12:0] W_S   = 13'(STROKE_W);
    localparam logic signed [12:0] H_S   = 13'(STROKE_H);
    localparam logic [11:0] STEP_U = 12'(STEP);
    localparam logic [11:0] MAX_U  = 12'(DELT_MAX);

    typedef enum logic {S_RIGHT, S_LEFT} dir_e;

    dir_e        state_q, state_d;
    logic [10:0] delt_q, delt_d;
    logic [11:0] up_sum, dn_sum;
    logic        frame_en;
    logic        visible;

    assign frame_en = frame_start & enable;

    always_comb begin
        state_d = state_q;
        delt_d  = delt_q;
        up_sum  = {1'b0, delt_q} + STEP_U;
        dn_sum  = {1'b0, delt_q} - STEP_U;
        if (frame_en) begin
            unique case (state_q)
                S_RIGHT: begin
                    if (up_sum >= MAX_U) begin
                        delt_d  = MAX_U[10:0];
                        state_d = S_LEFT;
                    end else begin
                        delt_d = up_sum[10:0];
                    end
                end
                S_LEFT: begin
                    // Clamp at zero instead of letting the subtraction wrap
                    if ({1'b0, delt_q} <= STEP_U) begin
                        delt_d  = '0;
                        state_d = S_RIGHT;
                    end else begin
                        delt_d = dn_sum[10:0];
                    end
                end
                default: begin
                    delt_d  = '0;
                    state_d = S_RIGHT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RIGHT;
            delt_q  <= '0;
        end else begin
            state_q <= state_d;
            delt_q  <= delt_d;
        end
    end

    assign delt = delt_q;

`ifdef LOGO_V_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES) + 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          vis_q, vis_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        vis_d       = vis_q;
        if (frame_en) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                vis_d       = ~vis_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            vis_q       <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            vis_q       <= vis_d;
        end
    end

    assign visible = vis_q;
`else
    assign visible = 1'b1;
`endif

    logic signed [12:0] xs, base_s;
    logic signed [12:0] r_d, dl_d, dr_d;
    logic signed [12:0] r_q, dl_q, dr_q;
    logic               pv_q, en_q;

    always_comb begin
        xs     = $signed({2'b00, x});
        base_s = $signed({2'b00, delt_q}) + X0_S;
        r_d    = $signed({2'b00, y}) - Y0_S;
        dl_d   = xs - base_s - r_d;
        dr_d   = xs - base_s - GAP_S + r_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q  <= '0;
            dl_q <= '0;
            dr_q <= '0;
            pv_q <= 1'b0;
            en_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            dl_q <= dl_d;
            dr_q <= dr_d;
            pv_q <= pix_valid;
            en_q <= enable;
        end
    end

    logic row_ok, bs_hit, fs_hit;
    logic hit_d, hit_q, hv_q;

    always_comb begin
        row_ok = (r_q >= 13'sd0) && (r_q < H_S);
        bs_hit = (dl_q >= 13'sd0) && (dl_q < W_S);
        fs_hit = (dr_q >= 13'sd0) && (dr_q < W_S);
        hit_d  = row_ok & (bs_hit | fs_hit) & pv_q & en_q & visible;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= 1'b0;
            hv_q  <= 1'b0;
        end else begin
            hit_q <= hit_d;
            hv_q  <= pv_q;
        end
    end

    assign hit       = hit_q;
    assign hit_valid = hv_q;

endmodule

// File: tb/tb_logo_v_animator.sv
// Bench for logo_v_animator: geometry/bounce model plus directed literal checks.
module tb_logo_v_animator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [10:0] x = '0;
    logic [10:0] y = '0;
    logic        hit, hit_valid;
    logic [10:0] delt;

    logo_v_animator dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .x           (x),
        .y           (y),
        .hit         (hit),
        .hit_valid   (hit_valid),
        .delt        (delt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bounce as a triangle wave of the number of enabled frames
    function automatic int tri_delt(input int n);
        int p;
        p = (n * 2) % 200;
        return (p <= 100) ? p : 200 - p;
    endfunction

    function automatic logic geo(input int px, input int py, input int d);
        int r, a, b;
        r = py - 560;
        if (r < 0 || r >= 20) return 1'b0;
        a = px - 500 - d - r;
        b = px - 540 - d + r;
        return (a >= 0 && a < 5) || (b >= 0 && b < 5);
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    int   nfr;
    logic e1, e2, v1, v2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            nfr <= 0;
            e1  <= 1'b0;
            e2  <= 1'b0;
            v1  <= 1'b0;
            v2  <= 1'b0;
        end else begin
            e1  <= geo(int'(x), int'(y), tri_delt(nfr)) & pix_valid & enable;
            e2  <= e1;
            v1  <= pix_valid;
            v2  <= v1;
            if (frame_start && enable) nfr <= nfr + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("model_hit", int'(hit), int'(e2));
            check("model_hit_valid", int'(hit_valid), int'(v2));
            check("model_delt", int'(delt), tri_delt(nfr));
        end
    end

    task automatic pix(input int px, input int py);
        @(negedge clk);
        x = 11'(px);
        y = 11'(py);
        pix_valid = 1'b1;
    endtask

    task automatic lit(input int px, input int py, input int exp, input string nm);
        pix(px, py);
        repeat (3) @(negedge clk);
        check(nm, int'(hit), exp);
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    int rows[5] = '{559, 560, 570, 579, 580};

    initial begin
        enable = 1'b1;
        #1;
        check("rst_hit", int'(hit), 0);
        check("rst_hit_valid", int'(hit_valid), 0);
        check("rst_delt", int'(delt), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        lit(500, 560, 1, "h500_560");
        lit(504, 560, 1, "h504_560");
        lit(505, 560, 0, "h505_560");
        lit(499, 560, 0, "h499_560");
        lit(540, 560, 1, "h540_560");
        lit(544, 560, 1, "h544_560");
        lit(519, 579, 1, "h519_579");
        lit(525, 579, 1, "h525_579");
        lit(518, 579, 0, "h518_579");
        lit(526, 579, 0, "h526_579");
        lit(520, 580, 0, "h520_580");
        lit(500, 559, 0, "h500_559");

        foreach (rows[i]) begin
            for (int px = 490; px <= 560; px++) pix(px, rows[i]);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);

        frame();
        check("delt_f1", int'(delt), 2);
        repeat (49) frame();
        check("delt_f50", int'(delt), 100);
        frame();
        check("delt_f51", int'(delt), 98);
        repeat (49) frame();
        check("delt_f100", int'(delt), 0);
        frame();
        check("delt_f101", int'(delt), 2);

        enable = 1'b0;
        repeat (10) frame();
        check("delt_frozen", int'(delt), 2);
        lit(502, 560, 0, "h_disabled");
        enable = 1'b1;
        lit(502, 560, 1, "h_enabled");

        repeat (2) frame();
        check("delt_pre_rst", int'(delt), 6);
        for (int px = 500; px < 520; px++) pix(px, 560);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_hit", int'(hit), 0);
        check("mid_rst_hit_valid", int'(hit_valid), 0);
        check("mid_rst_delt", int'(delt), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        pix_valid = 1'b0;
        frame();
        check("delt_post_rst", int'(delt), 2);
        lit(502, 560, 1, "h_post_rst");
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
